int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_pkg.sv | 41 ++++
 rtl/int_pend_latch.sv | 32 +++
 rtl/int_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared constants, types and helpers for the interrupt controller.
package int_pkg;

  localparam int unsigned NumSrc    = 5;
  localparam int unsigned IdxW      = 3;
  localparam int unsigned NumLvl    = 2;
  localparam logic [15:0] VecBase   = 16'h0003;
  localparam int unsigned VecStride = 8;

  typedef logic [IdxW-1:0] src_idx_t;

  localparam src_idx_t SrcEx0    = 3'd0;
  localparam src_idx_t SrcT0     = 3'd1;
  localparam src_idx_t SrcEx1    = 3'd2;
  localparam src_idx_t SrcT1     = 3'd3;
  localparam src_idx_t SrcSerial = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StPushLo,
    StPushHi,
    StVector
  } int_state_e;

  function automatic logic [15:0] vector_addr(src_idx_t idx);
    logic [15:0] offset;
    offset = 16'(idx) * 16'(VecStride);
    return VecBase + offset;
  endfunction

  // Lowest set index wins; scanning downwards leaves the lowest one last.
  function automatic src_idx_t lowest_idx(logic [NumSrc-1:0] v);
    src_idx_t idx;
    idx = '0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (v[i]) idx = src_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_pend_latch.sv
// One interrupt source: rising-edge detector feeding a sticky pending bit.
module int_pend_latch (
  input  logic clock,
  input  logic reset,
  input  logic irq_i,
  input  logic clr_i,
  output logic pending_o
);

  logic irq_q;
  logic pend_q, pend_d;

  // A new edge beats a simultaneous clear so no request is lost.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    if (irq_i && !irq_q) pend_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: arbitration, PC push and vectoring sequence.
// Define INT_PRIO_NEST_EN for two priority levels with high-over-low nesting.
module int_ctrl
  import int_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [NumSrc-1:0] irq,
  input  logic              ea,
  input  logic [NumSrc-1:0] ie_mask,
  input  logic [NumSrc-1:0] ip,
  input  logic              cpu_int_en,
  input  logic              reti,
  input  logic [15:0]       pc_in,
  output logic              int_req,    // stall request ("int" is a reserved word)
  output logic              stack_push,
  output logic [7:0]        stack_data,
  output logic              pc_load,
  output logic [15:0]       pc_vector,
  output logic [NumLvl-1:0] in_service
);

  logic [NumSrc-1:0] pending, pend_clr, eligible;
  logic [NumLvl-1:0] in_service_q, in_service_d, svc_set, svc_clr;

  int_state_e  state_q, state_d;
  logic [15:0] cap_pc_q, cap_pc_d;
  src_idx_t    cap_idx_q, cap_idx_d;
  logic        cap_lvl_q, cap_lvl_d;

  logic     win_found;
  src_idx_t win_idx;
  logic     win_lvl;

  for (genvar g = 0; g < NumSrc; g++) begin : g_pend
    int_pend_latch u_pend (
      .clock     (clock),
      .reset     (reset),
      .irq_i     (irq[g]),
      .clr_i     (pend_clr[g]),
      .pending_o (pending[g])
    );
  end

  assign eligible = pending & ie_mask & {NumSrc{ea}};

`ifdef INT_PRIO_NEST_EN
  logic [NumSrc-1:0] hi_cand, lo_cand;
  assign hi_cand = eligible & ip;
  assign lo_cand = eligible & ~ip;

  // A level may only enter when it is above the highest level in service.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_lvl   = 1'b0;
    if (!in_service_q[1] && (|hi_cand)) begin
      win_found = 1'b1;
      win_idx   = lowest_idx(hi_cand);
      win_lvl   = 1'b1;
    end else if ((in_service_q == '0) && (|lo_cand)) begin
      win_found = 1'b1;
      win_idx   = lowest_idx(lo_cand);
    end
  end
`else
  logic unused_ip;
  assign unused_ip = ^ip;

  // Single level: nothing enters while a service routine is running.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_lvl   = 1'b0;
    if (!in_service_q[0] && (|eligible)) begin
      win_found = 1'b1;
      win_idx   = lowest_idx(eligible);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cap_pc_d  = cap_pc_q;
    cap_idx_d = cap_idx_q;
    cap_lvl_d = cap_lvl_q;
    pend_clr  = '0;
    svc_set   = '0;
    unique case (state_q)
      StIdle: begin
        if (cpu_int_en && win_found) begin
          state_d   = StPushLo;
          cap_pc_d  = pc_in;
          cap_idx_d = win_idx;
          cap_lvl_d = win_lvl;
        end
      end
      StPushLo: state_d = StPushHi;
      StPushHi: state_d = StVector;
      StVector: begin
        state_d             = StIdle;
        pend_clr[cap_idx_q] = 1'b1;
        svc_set[cap_lvl_q]  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // RETI retires the highest active level; with nothing active it is a no-op.
  always_comb begin
    svc_clr = '0;
    if (reti) begin
      if (in_service_q[1])      svc_clr = 2'b10;
      else if (in_service_q[0]) svc_clr = 2'b01;
    end
    in_service_d = (in_service_q & ~svc_clr) | svc_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cap_pc_q     <= '0;
      cap_idx_q    <= '0;
      cap_lvl_q    <= 1'b0;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      cap_pc_q     <= cap_pc_d;
      cap_idx_q    <= cap_idx_d;
      cap_lvl_q    <= cap_lvl_d;
      in_service_q <= in_service_d;
    end
  end

  always_comb begin
    int_req    = (state_q != StIdle);
    stack_push = 1'b0;
    stack_data = '0;
    pc_load    = 1'b0;
    pc_vector  = '0;
    unique case (state_q)
      StPushLo: begin
        stack_push = 1'b1;
        stack_data = cap_pc_q[7:0];
      end
      StPushHi: begin
        stack_push = 1'b1;
        stack_data = cap_pc_q[15:8];
      end
      StVector: begin
        pc_load   = 1'b1;
        pc_vector = vector_addr(cap_idx_q);
      end
      default: ;
    endcase
  end

  assign in_service = in_service_q;

endmodule
